// File: rtl/usb_rx_packet.sv
// usb_rx_packet: packet-layer decoder downstream of usb_rx.
// Checks the PID check nibble, token CRC5 and data CRC16. Outputs the PID,
// the token fields, the payload stream with the CRC bytes stripped, and a
// one-cycle end-of-packet status.
//   clk, reset_n                       clock, async active-low reset
//   rx_data/rx_valid/rx_active/rx_error byte stream and framing from usb_rx
//   pid, pid_valid                     decoded PID and its update strobe
//   addr, endp, frame                  token fields, latched on good tokens
//   pd_data, pd_valid                  payload bytes without CRC16
//   pkt_end, pkt_ok                    end-of-packet pulse and status
//   pid_err, crc_err, len_err, rx_err  error flags, held like pkt_ok
module usb_rx_packet #(
    parameter int unsigned MAX_PAYLOAD = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_active,
    input  logic        rx_error,
    output logic [3:0]  pid,
    output logic        pid_valid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [10:0] frame,
    output logic [7:0]  pd_data,
    output logic        pd_valid,
    output logic        pkt_end,
    output logic        pkt_ok,
    output logic        pid_err,
    output logic        crc_err,
    output logic        len_err,
    output logic        rx_err
);

    localparam int unsigned      CNT_W    = $clog2(MAX_PAYLOAD + 3);
    localparam logic [CNT_W-1:0] DATA_MAX = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [4:0]       RES5     = 5'b01100;
    localparam logic [15:0]      RES16    = 16'h800D;

    typedef enum logic [2:0] {S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_DROP} state_t;

    state_t           state, state_d;
    logic             act_q;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [4:0]       crc5, crc5_d;
    logic [15:0]      crc16, crc16_d;
    logic [7:0]       dl0, dl0_d, dl1, dl1_d, tb1, tb1_d;
    logic [2:0]       tb2, tb2_d;
    logic             e_pid, e_pid_d, e_len, e_len_d, e_rx, e_rx_d;
    logic [3:0]       pid_d, endp_d;
    logic [6:0]       addr_d;
    logic [10:0]      frame_d;
    logic [7:0]       pd_data_d;
    logic             pid_valid_d, pd_valid_d, pkt_end_d, pkt_ok_d;
    logic             pid_err_d, crc_err_d, len_err_d, rx_err_d;
    logic             err_in, c_len, c_crc, fin_bad;

    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++)
            r = {r[3:0], 1'b0} ^ ((d[i] ^ r[4]) ? 5'b00101 : 5'b00000);
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++)
            r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? 16'h8005 : 16'h0000);
        return r;
    endfunction

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        crc5_d      = crc5;
        crc16_d     = crc16;
        dl0_d       = dl0;
        dl1_d       = dl1;
        tb1_d       = tb1;
        tb2_d       = tb2;
        e_pid_d     = e_pid;
        e_len_d     = e_len;
        e_rx_d      = e_rx;
        pid_d       = pid;
        addr_d      = addr;
        endp_d      = endp;
        frame_d     = frame;
        pd_data_d   = pd_data;
        pid_valid_d = 1'b0;
        pd_valid_d  = 1'b0;
        pkt_end_d   = 1'b0;
        pkt_ok_d    = pkt_ok;
        pid_err_d   = pid_err;
        crc_err_d   = crc_err;
        len_err_d   = len_err;
        rx_err_d    = rx_err;
        c_len       = 1'b0;
        c_crc       = 1'b0;
        fin_bad     = 1'b0;
        err_in      = rx_active && rx_error;

        case (state)
            S_IDLE: begin
                if (rx_active && !act_q) begin
                    state_d   = S_PID;
                    cnt_d     = '0;
                    crc5_d    = '1;
                    crc16_d   = '1;
                    e_pid_d   = 1'b0;
                    e_len_d   = 1'b0;
                    e_rx_d    = 1'b0;
                    pkt_ok_d  = 1'b0;
                    pid_err_d = 1'b0;
                    crc_err_d = 1'b0;
                    len_err_d = 1'b0;
                    rx_err_d  = 1'b0;
                end
            end
            S_PID: begin
                if (err_in) begin
                    e_rx_d  = 1'b1;
                    state_d = S_DROP;
                end else if (rx_valid) begin
                    if (rx_data[7:4] != ~rx_data[3:0]) begin
                        e_pid_d = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        pid_d       = rx_data[3:0];
                        pid_valid_d = 1'b1;
                        case (rx_data[1:0])
                            2'b01:   state_d = S_TOKEN;
                            2'b11:   state_d = S_DATA;
                            2'b10:   state_d = S_HSK;
                            default: begin
                                e_len_d = 1'b1;
                                state_d = S_DROP;
                            end
                        endcase
                    end
                end
            end
            S_TOKEN: begin
                if (err_in) begin
                    e_rx_d  = 1'b1;
                    state_d = S_DROP;
                end else if (rx_valid) begin
                    if (cnt == TWO) begin
                        e_len_d = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        crc5_d = crc5_byte(crc5, rx_data);
                        cnt_d  = cnt + 1'b1;
                        if (cnt == '0) tb1_d = rx_data;
                        else           tb2_d = rx_data[2:0];
                    end
                end
            end
            S_DATA: begin
                if (err_in) begin
                    e_rx_d  = 1'b1;
                    state_d = S_DROP;
                end else if (rx_valid) begin
                    if (cnt == DATA_MAX) begin
                        e_len_d = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        crc16_d = crc16_byte(crc16, rx_data);
                        cnt_d   = cnt + 1'b1;
                        // Two-byte delay line: the last two bytes (CRC16) never leave it.
                        if (cnt >= TWO) begin
                            pd_data_d  = dl1;
                            pd_valid_d = 1'b1;
                        end
                        dl1_d = dl0;
                        dl0_d = rx_data;
                    end
                end
            end
            S_HSK: begin
                if (err_in) begin
                    e_rx_d  = 1'b1;
                    state_d = S_DROP;
                end else if (rx_valid) begin
                    e_len_d = 1'b1;
                    state_d = S_DROP;
                end
            end
            default: ;
        endcase

        // Close evaluates the post-byte values so a byte arriving with the
        // falling edge of rx_active is included. CRC is only judged when the
        // length is plausible.
        if (state != S_IDLE && !rx_active) begin
            case (state_d)
                S_PID:   c_len = 1'b1;
                S_TOKEN: begin
                    c_len = (cnt_d != TWO);
                    c_crc = !c_len && (crc5_d != RES5);
                end
                S_DATA:  begin
                    c_len = (cnt_d < TWO);
                    c_crc = !c_len && (crc16_d != RES16);
                end
                default: ;
            endcase
            fin_bad   = e_pid_d | e_len_d | e_rx_d | c_len | c_crc;
            pkt_end_d = 1'b1;
            pkt_ok_d  = !fin_bad;
            pid_err_d = e_pid_d;
            crc_err_d = c_crc;
            len_err_d = e_len_d | c_len;
            rx_err_d  = e_rx_d;
            if (state_d == S_TOKEN && !fin_bad) begin
                addr_d  = tb1_d[6:0];
                endp_d  = {tb2_d, tb1_d[7]};
                frame_d = {tb2_d, tb1_d};
            end
            state_d = S_IDLE;
        end
    end

    // act_q resets high so a packet already in flight at reset release is
    // not mistaken for a new SYNC; it waits for rx_active to fall and rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            act_q     <= 1'b1;
            cnt       <= '0;
            crc5      <= '1;
            crc16     <= '1;
            dl0       <= '0;
            dl1       <= '0;
            tb1       <= '0;
            tb2       <= '0;
            e_pid     <= 1'b0;
            e_len     <= 1'b0;
            e_rx      <= 1'b0;
            pid       <= '0;
            pid_valid <= 1'b0;
            addr      <= '0;
            endp      <= '0;
            frame     <= '0;
            pd_data   <= '0;
            pd_valid  <= 1'b0;
            pkt_end   <= 1'b0;
            pkt_ok    <= 1'b0;
            pid_err   <= 1'b0;
            crc_err   <= 1'b0;
            len_err   <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            state     <= state_d;
            act_q     <= rx_active;
            cnt       <= cnt_d;
            crc5      <= crc5_d;
            crc16     <= crc16_d;
            dl0       <= dl0_d;
            dl1       <= dl1_d;
            tb1       <= tb1_d;
            tb2       <= tb2_d;
            e_pid     <= e_pid_d;
            e_len     <= e_len_d;
            e_rx      <= e_rx_d;
            pid       <= pid_d;
            pid_valid <= pid_valid_d;
            addr      <= addr_d;
            endp      <= endp_d;
            frame     <= frame_d;
            pd_data   <= pd_data_d;
            pd_valid  <= pd_valid_d;
            pkt_end   <= pkt_end_d;
            pkt_ok    <= pkt_ok_d;
            pid_err   <= pid_err_d;
            crc_err   <= crc_err_d;
            len_err   <= len_err_d;
            rx_err    <= rx_err_d;
        end
    end

endmodule

// File: tb/tb_usb_rx_packet.sv
// tb_usb_rx_packet: directed bench for usb_rx_packet.
// Token CRC5 bytes are hand-derived (2D 05 D0, A5 10 2F). Data CRC16 bytes
// come from the reflected USB CRC16 form (poly 0xA001, init 0xFFFF, sent
// inverted, low byte first), independent of the MSB-first form in the DUT.
module tb_usb_rx_packet;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_active, rx_error;
    logic [3:0]  pid;
    logic        pid_valid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
    logic [7:0]  pd_data;
    logic        pd_valid, pkt_end, pkt_ok, pid_err, crc_err, len_err, rx_err;

    usb_rx_packet #(.MAX_PAYLOAD(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_active(rx_active), .rx_error(rx_error),
        .pid(pid), .pid_valid(pid_valid), .addr(addr), .endp(endp), .frame(frame),
        .pd_data(pd_data), .pd_valid(pd_valid), .pkt_end(pkt_end), .pkt_ok(pkt_ok),
        .pid_err(pid_err), .crc_err(crc_err), .len_err(len_err), .rx_err(rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_pidv   = 0;
    logic [7:0] pd_q [$];
    logic [7:0] tx [$];
    logic [7:0] pat [11] = '{8'h3A, 8'h7F, 8'h01, 8'hC5, 8'h99, 8'hE2,
                             8'h40, 8'h1B, 8'h6D, 8'hA8, 8'h5E};

    // Payload and PID strobes are collected on the falling edge.
    always @(negedge clk) begin
        if (pd_valid) pd_q.push_back(pd_data);
        if (pid_valid) n_pidv++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {22'd0, pid, pid_valid, addr, endp, frame, pd_data, pd_valid,
                pkt_end, pkt_ok, pid_err, crc_err, len_err, rx_err};
    endfunction

    task automatic build_data(input logic [7:0] p, input int n);
        logic [15:0] r;
        tx.delete();
        tx.push_back(p);
        r = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            tx.push_back(pat[i]);
            r = r ^ {8'h00, pat[i]};
            for (int k = 0; k < 8; k++)
                r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        r = ~r;
        tx.push_back(r[7:0]);
        tx.push_back(r[15:8]);
    endtask

    // Sends tx as one packet, a byte every second clock. err_at pulses
    // rx_error before that byte index; fall_last drops rx_active together
    // with the last byte. Status {ok,pid,crc,len,rx} is checked at pkt_end.
    task automatic send(input string tag, input int err_at, input bit fall_last,
                        input logic [4:0] exp_st);
        rx_active = 1'b1;
        tick();
        check({tag, "_start_clr"}, {pkt_ok, pid_err, crc_err, len_err, rx_err}, 5'b00000);
        for (int i = 0; i < tx.size(); i++) begin
            if (i == err_at) begin
                rx_error = 1'b1;
                tick();
                rx_error = 1'b0;
            end
            rx_data  = tx[i];
            rx_valid = 1'b1;
            if (fall_last && i == tx.size() - 1) rx_active = 1'b0;
            tick();
            rx_valid = 1'b0;
            if (rx_active) tick();
        end
        if (rx_active) begin
            rx_active = 1'b0;
            tick();
        end
        check({tag, "_pkt_end"}, pkt_end, 1'b1);
        check({tag, "_status"}, {pkt_ok, pid_err, crc_err, len_err, rx_err}, exp_st);
    endtask

    task automatic check_pd(input string tag, input int base, input int n);
        check({tag, "_pd_cnt"}, pd_q.size() - base, n);
        for (int k = 0; k < n; k++)
            if (base + k < pd_q.size())
                check({tag, "_pd_byte"}, pd_q[base + k], tx[1 + k]);
    endtask

    int base, pv0;

    initial begin
        reset_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_active = 1'b0; rx_error = 1'b0;
        repeat (3) tick();
        check("reset_outs", all_outs(), 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // DATA0, good CRC, last byte coincident with rx_active falling
        build_data(8'hC3, 8);
        base = pd_q.size(); pv0 = n_pidv;
        send("data0", -1, 1'b1, 5'b10000);
        repeat (2) tick();
        check_pd("data0", base, 8);
        check("data0_pidv", n_pidv - pv0, 1);
        check("data0_pid", pid, 4'h3);
        repeat (3) tick();
        check("data0_ok_held", pkt_ok, 1'b1);

        // DATA1 with one payload bit flipped after the CRC was computed
        build_data(8'h4B, 8);
        tx[4] = tx[4] ^ 8'h10;
        base = pd_q.size();
        send("data1_bad", -1, 1'b0, 5'b00100);
        repeat (2) tick();
        check_pd("data1_bad", base, 8);
        check("data1_pid", pid, 4'hB);

        // DATA with a single byte after the PID: too short
        tx = '{8'hC3, 8'h00};
        base = pd_q.size();
        send("data_short", -1, 1'b0, 5'b00010);
        repeat (2) tick();
        check("data_short_pd", pd_q.size() - base, 0);

        // PRE/ERR class PID (pid[1:0] = 00) passes the check nibble
        tx = '{8'h3C};
        pv0 = n_pidv;
        send("pre", -1, 1'b0, 5'b00010);
        repeat (2) tick();
        check("pre_pidv", n_pidv - pv0, 1);
        check("pre_pid", pid, 4'hC);

        // Reset in the middle of a DATA packet
        build_data(8'hC3, 8);
        rx_active = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            rx_data = tx[i]; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick();
        end
        reset_n = 1'b0;
        #1;
        check("rst_mid_outs", all_outs(), 64'd0);
        tick();
        reset_n = 1'b1;
        base = pd_q.size(); pv0 = n_pidv;
        for (int i = 4; i < tx.size(); i++) begin
            rx_data = tx[i]; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick();
        end
        rx_active = 1'b0;
        tick();
        check("rst_no_end", pkt_end, 1'b0);
        repeat (2) tick();
        check("rst_no_pd", pd_q.size() - base, 0);
        check("rst_no_pidv", n_pidv - pv0, 0);

        // SETUP addr 5 endp 0
        tx = '{8'h2D, 8'h05, 8'hD0};
        send("setup", -1, 1'b0, 5'b10000);
        repeat (2) tick();
        check("setup_addr", addr, 7'h05);
        check("setup_endp", endp, 4'h0);
        check("setup_pid", pid, 4'hD);

        // SOF frame 0x710
        tx = '{8'hA5, 8'h10, 8'h2F};
        send("sof", -1, 1'b0, 5'b10000);
        repeat (2) tick();
        check("sof_frame", frame, 11'h710);
        check("sof_addr", addr, 7'h10);
        check("sof_endp", endp, 4'hE);

        // Token with a corrupted CRC5: fields must not be latched
        tx = '{8'h2D, 8'h05, 8'hD1};
        send("tok_bad", -1, 1'b0, 5'b00100);
        repeat (2) tick();
        check("tok_bad_addr", addr, 7'h10);
        check("tok_bad_frame", frame, 11'h710);

        // ACK then corrupted PID, back to back (second starts in pkt_end cycle)
        pv0 = n_pidv;
        tx = '{8'hD2};
        send("ack", -1, 1'b0, 5'b10000);
        tx = '{8'hD3};
        send("bad_pid", -1, 1'b0, 5'b01000);
        repeat (2) tick();
        check("ack_pidv", n_pidv - pv0, 1);
        check("ack_pid", pid, 4'h2);

        // Handshake with a trailing byte
        tx = '{8'hD2, 8'h00};
        send("hsk_long", -1, 1'b0, 5'b00010);
        repeat (2) tick();

        // DATA0 with 11 payload bytes: overflow on the 11th byte after PID
        build_data(8'hC3, 11);
        base = pd_q.size();
        send("data_long", -1, 1'b0, 5'b00010);
        repeat (2) tick();
        check_pd("data_long", base, 8);

        // rx_error pulsed before the 5th byte: only two payload bytes escape
        build_data(8'hC3, 8);
        base = pd_q.size();
        send("rx_error", 5, 1'b0, 5'b00001);
        repeat (2) tick();
        check_pd("rx_error", base, 2);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
